// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART register block's APB path.
package uart_apb_pkg;

  // Default bus widths for the UART register block.
  localparam int unsigned ApbAddrW = 8;
  localparam int unsigned ApbDataW = 8;

  // APB initiator transfer phases.
  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_t;

  // UART register map.
  localparam logic [ApbAddrW-1:0] UartAddrBaud   = 8'h00;
  localparam logic [ApbAddrW-1:0] UartAddrTxData = 8'h01;
  localparam logic [ApbAddrW-1:0] UartAddrTxCtrl = 8'h02;
  localparam logic [ApbAddrW-1:0] UartAddrRxStat = 8'h04;
  localparam logic [ApbAddrW-1:0] UartAddrRxData = 8'h05;

endpackage

// File: rtl/apb_wait_timer.sv
// Bounded-wait counter for the APB ACCESS phase. expired is high while the
// count equals TIMEOUT_CYCLES-1; a TIMEOUT_CYCLES of 0 never expires.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TMR_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] Limit =
      (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt_q;

  // Wait counter: clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + TMR_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == Limit);

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns one command into a SETUP/ACCESS transfer and returns a
// one-cycle response carrying read data, slave error and timeout status.
module apb_master
  import uart_apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ApbAddrW,
  parameter int unsigned DATA_W         = ApbDataW,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TMR_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    tmr_clear     = 1'b0;
    tmr_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          // Reads leave pwdata at its last value; the slave ignores it.
          if (cmd_write) begin
            pwdata_d = cmd_wdata;
          end
          psel_d    = 1'b1;
          penable_d = 1'b0;
          tmr_clear = 1'b1;
          state_d   = StSetup;
        end
      end

      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end

      StAccess: begin
        // pready is checked first so a late ready beats the timeout.
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
          state_d       = StResp;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            state_d       = StResp;
          end
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a behavioural APB slave with
// programmable wait states/errors, and a reference model that predicts bus
// phases, response timing and response contents per command.
module tb_apb_master;
  import uart_apb_pkg::*;

  localparam int unsigned Timeout = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata = '0;
  logic       pready = 1'b0;
  logic       pslverr = 1'b0;

  apb_master #(
    .ADDR_W        (8),
    .DATA_W        (8),
    .TIMEOUT_CYCLES(Timeout),
    .TMR_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Slave configuration and storage.
  int         wait_cfg = 0;
  bit         err_cfg = 1'b0;
  int         acc_cnt = 0;
  logic [7:0] slv_mem [256];

  // Reference model state.
  logic [7:0] ref_mem [256];
  logic [7:0] last_wdata = '0;
  logic       prev_err = 1'b0;
  logic       prev_to = 1'b0;
  logic [7:0] prev_rdata = '0;

  logic [7:0] addr_set [5];

  // Behavioural slave: ready after wait_cfg ACCESS cycles, noise elsewhere.
  always @(negedge clk) begin
    if (psel && penable) begin
      pready  = (acc_cnt == wait_cfg);
      pslverr = pready ? err_cfg : 1'($urandom);
      prdata  = pready ? slv_mem[paddr] : 8'($urandom);
      if (pready && pwrite && !err_cfg) slv_mem[paddr] = pwdata;
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = 8'($urandom);
    end
  end

  function automatic logic [30:0] observe();
    return {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_timeout,
            rsp_rdata, cmd_ready};
  endfunction

  // Issue one command and check every cycle from SETUP to the response.
  task automatic do_cmd(input string tag, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wd, input int waits, input bit err,
                        input bit chain, output int t_acc);
    int         n;
    bit         to;
    logic       e_err;
    logic       e_to;
    logic [7:0] e_rdata;
    logic [7:0] e_pwdata;
    logic [30:0] exp_v;
    logic [30:0] obs_v;
    int         guard;

    to = (waits >= int'(Timeout));
    n  = to ? int'(Timeout) : waits + 1;
    if (to) begin
      e_err = 1'b1; e_to = 1'b1; e_rdata = '0;
    end else begin
      e_err   = err;
      e_to    = 1'b0;
      e_rdata = (!wr && !err) ? ref_mem[addr] : 8'h00;
      if (wr && !err) ref_mem[addr] = wd;
    end
    e_pwdata = wr ? wd : last_wdata;

    wait_cfg  = waits;
    err_cfg   = err;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (!cmd_ready) begin
      miscompares++;
      $display("FAIL %s accept: cmd_ready=%b required 1 within 20 cycles", tag, cmd_ready);
      cmd_valid = 1'b0;
      t_acc = cyc;
      return;
    end
    @(negedge clk);
    t_acc = cyc;

    for (int d = 0; d <= n + 1; d++) begin
      if (d > 0) @(negedge clk);
      if (d <= n) begin
        exp_v = {1'b1, (d >= 1), wr, addr, e_pwdata, 1'b0, prev_err, prev_to, prev_rdata,
                 1'b0};
      end else begin
        exp_v = {1'b0, 1'b0, wr, addr, e_pwdata, 1'b1, e_err, e_to, e_rdata, 1'b0};
      end
      obs_v = observe();
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s phase d=%0d: got %h required %h", tag, d, obs_v, exp_v);
      end
      // Commands offered outside IDLE must be ignored.
      if (d == n + 1) begin
        cmd_valid = chain;
      end else begin
        cmd_valid = 1'($urandom);
      end
      cmd_write = 1'($urandom);
      cmd_addr  = 8'($urandom);
      cmd_wdata = 8'($urandom);
    end

    prev_err   = e_err;
    prev_to    = e_to;
    prev_rdata = e_rdata;
    if (wr) last_wdata = wd;
  endtask

  task automatic test_reset();
    logic [30:0] exp_v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp_v = 31'h1;
    vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL reset_hold: got %h required %h", observe(), exp_v);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL reset_release: got %h required %h", observe(), exp_v);
    end
  endtask

  task automatic test_write_basic();
    int t;
    do_cmd("write_basic", 1'b1, UartAddrTxData, 8'h5A, 0, 1'b0, 1'b0, t);
  endtask

  task automatic test_read_wait();
    int t;
    slv_mem[UartAddrRxData] = 8'hC3;
    ref_mem[UartAddrRxData] = 8'hC3;
    do_cmd("read_wait3", 1'b0, UartAddrRxData, 8'h00, 3, 1'b0, 1'b0, t);
  endtask

  task automatic test_slverr();
    int t;
    do_cmd("write_slverr", 1'b1, UartAddrTxCtrl, 8'h77, 0, 1'b1, 1'b0, t);
    do_cmd("read_slverr", 1'b0, UartAddrRxData, 8'h00, 2, 1'b1, 1'b0, t);
  endtask

  task automatic test_timeout();
    int t;
    do_cmd("timeout_stuck", 1'b0, UartAddrRxStat, 8'h00, 1000, 1'b0, 1'b0, t);
    do_cmd("ready_at_limit", 1'b0, UartAddrRxData, 8'h00, Timeout - 1, 1'b0, 1'b0, t);
    do_cmd("timeout_edge", 1'b1, UartAddrBaud, 8'h21, Timeout, 1'b0, 1'b0, t);
    do_cmd("after_timeout", 1'b1, UartAddrBaud, 8'h34, 0, 1'b0, 1'b0, t);
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    do_cmd("b2b_0", 1'b1, UartAddrTxData, 8'hA1, 0, 1'b0, 1'b1, t0);
    do_cmd("b2b_1", 1'b0, UartAddrTxData, 8'h00, 2, 1'b0, 1'b1, t1);
    do_cmd("b2b_2", 1'b0, UartAddrBaud, 8'h00, 0, 1'b0, 1'b0, t2);
    vectors++;
    if (t1 - t0 !== 4) begin
      miscompares++;
      $display("FAIL b2b_spacing01: got %0d required 4", t1 - t0);
    end
    vectors++;
    if (t2 - t1 !== 6) begin
      miscompares++;
      $display("FAIL b2b_spacing12: got %0d required 6", t2 - t1);
    end
  endtask

  task automatic test_reset_mid();
    logic [30:0] exp_v;
    int guard;
    int t;
    wait_cfg  = 1000;
    err_cfg   = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = UartAddrRxData;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_v = 31'h1;
    vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL reset_mid_edge: got %h required %h", observe(), exp_v);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (observe() !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid_after c=%0d: got %h required %h", i, observe(), exp_v);
      end
    end
    prev_err   = 1'b0;
    prev_to    = 1'b0;
    prev_rdata = '0;
    last_wdata = '0;
    do_cmd("post_reset", 1'b0, UartAddrRxData, 8'h00, 1, 1'b0, 1'b0, t);
  endtask

  task automatic test_random();
    int         t;
    int         waits;
    bit         wr;
    bit         err;
    logic [7:0] addr;
    for (int i = 0; i < 30; i++) begin
      wr   = 1'($urandom);
      addr = addr_set[$urandom_range(0, 4)];
      case ($urandom_range(0, 7))
        5:       waits = Timeout - 1;
        6:       waits = Timeout;
        7:       waits = $urandom_range(17, 25);
        default: waits = $urandom_range(0, 3);
      endcase
      err = ($urandom_range(0, 5) == 0);
      do_cmd("random", wr, addr, 8'($urandom), waits, err,
             (i != 29) && 1'($urandom), t);
    end
  endtask

  initial begin
    addr_set[0] = UartAddrBaud;
    addr_set[1] = UartAddrTxData;
    addr_set[2] = UartAddrTxCtrl;
    addr_set[3] = UartAddrRxStat;
    addr_set[4] = UartAddrRxData;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end

    test_reset();
    test_write_basic();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB initiator that drives the UART register block's APB slave port from a simple command/response interface. Used by the test harness and the control core. Converts one command into a standard two-phase APB transfer (SETUP then ACCESS). Waits for PREADY and returns read data and error status. A bounded-wait timeout prevents a hung slave from stalling the initiator.

Parameters:
ADDR_W, 8, APB address width (paddr, cmd_addr)
DATA_W, 8, APB data width (pwdata, prdata, cmd_wdata, rsp_rdata)
TIMEOUT_CYCLES, 16, max ACCESS-phase wait cycles before abort; 0 disables timeout
TMR_W, 8, width of wait counter; must satisfy TIMEOUT_CYCLES < 2**TMR_W

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  master can accept command (high only in IDLE)
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse: transfer complete
rsp_rdata  out  DATA_W  read data; 0 for writes, errors and timeouts
rsp_err  out  1  slave error or timeout; qualified by rsp_valid
rsp_timeout  out  1  transfer aborted by timeout; qualified by rsp_valid
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- All outputs registered except cmd_ready (= state==IDLE).
- Reset values: state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0; paddr, pwdata, rsp_rdata = 0; wait counter = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on cmd_valid at edge T, latch cmd_write/addr/wdata onto pwrite/paddr/pwdata, then go to SETUP.
- SETUP (cycle T+1): psel=1, penable=0, then go to ACCESS unconditionally. pready is ignored in SETUP.
- ACCESS (cycle T+2 onward): psel=1, penable=1; paddr, pwrite, pwdata held stable.
  - If pready=1 at the edge: capture prdata (reads only), capture pslverr into rsp_err, then go to RESP; psel and penable drop on the same edge.
  - If pready=0: increment wait counter. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1, abort: psel and penable drop, rsp_err=1, rsp_timeout=1, rsp_rdata=0, then go to RESP.
  - Wait counter clears on entry to SETUP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. rsp_* fields hold until the next transfer completes.
- Latency with zero wait states: accept at T, rsp_valid at T+3. The next accept can happen at T+4, i.e. four cycles per transfer minimum.
- pwrite=0 transfers: pwdata keeps its last value (don't-care to slave).
- pslverr on a write: rsp_err=1, rsp_rdata=0.
- pready and timeout on the same edge: pready wins; the transfer completes normally.
- Reset mid-transfer (any state): on the reset edge, psel/penable drop and the FSM returns to IDLE. No rsp_valid is issued for the aborted command.
- cmd_valid outside IDLE is ignored (cmd_ready=0). The requester must hold the command until accepted.

Decomposition:
- Shared package uart_apb_pkg:
  - apb_state_t enum (IDLE, SETUP, ACCESS, RESP)
  - default ADDR_W/DATA_W constants
  - UART register address constants (BAUD=0, TX_DATA=1, TX_CTRL=2, RX_STAT=4, RX_DATA=5)
- One natural sub-module, apb_wait_timer: clear/enable inputs, expired output at TIMEOUT_CYCLES-1, disabled when TIMEOUT_CYCLES=0.

Test Plan:
- Write 0x5A to addr 0x01, pready tied 1:
  - accept at T; psel=1/penable=0 at T+1; penable=1 at T+2; rsp_valid at T+3.
  - rsp_err=0; paddr=0x01 and pwdata=0x5A stable through SETUP and ACCESS.
- Read addr 0x05, pready low for 3 ACCESS cycles, prdata=0xC3: penable high 4 cycles; rsp_rdata=0xC3, rsp_err=0; rsp_valid at T+6.
- Write with pslverr=1 alongside pready: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- pready stuck 0, TIMEOUT_CYCLES=16: psel drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1. Next command accepted normally.
- Back-to-back: cmd_valid held high with 3 queued commands: accepts spaced 4 cycles apart; responses in order, data matches.
- Assert rst during ACCESS of a read: psel/penable=0 next cycle; no rsp_valid; cmd_ready=1 after reset releases.
